// File: rtl/demux64x1_8_buf.sv
// Routes one input word to one of 8 single-entry output buffers selected by sel.
// Valid/ready on the producer side, valid/ack per consumer, plus an accepted-word counter.
module demux64x1_8_buf #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [2:0]            sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0][WIDTH-1:0] out_data,
  output logic [7:0]            out_valid,
  input  logic [7:0]            out_ack,
  output logic [CNT_W-1:0]      accept_cnt
);

  // channel valid bit | meaning
  // 0                 | EMPTY: accepts a new word
  // 1                 | FULL : holds a word until its consumer acks
  logic       accept;
  logic [7:0] wr_en;

  // A full channel that is being acked this cycle can take the next word (pass-through refill).
  assign in_ready = ~out_valid[sel] | out_ack[sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < 8; i++) begin
      wr_en[i] = accept & (sel == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= '0;
      out_valid  <= '0;
      accept_cnt <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) begin
          out_data[i]  <= in_data;
          out_valid[i] <= 1'b1;
        end else if (out_ack[i]) begin
          // Data is left in place after consumption; only the valid bit drops.
          out_valid[i] <= 1'b0;
        end
      end
      if (accept) begin
        accept_cnt <= accept_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux64x1_8_buf.sv
// Directed table vectors, counter wrap on a narrow-counter instance, reset-over-accept,
// and a randomised run against a per-channel queue scoreboard.
module tb_demux64x1_8_buf;

  logic            clk = 1'b0;
  logic            reset;
  logic [63:0]     in_data;
  logic [2:0]      sel;
  logic            in_valid;
  logic            in_ready;
  logic [7:0][63:0] out_data;
  logic [7:0]      out_valid;
  logic [7:0]      out_ack;
  logic [15:0]     accept_cnt;

  logic            in_ready4;
  logic [7:0][63:0] out_data4;
  logic [7:0]      out_valid4;
  logic [3:0]      accept_cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux64x1_8_buf #(.WIDTH(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
    .accept_cnt(accept_cnt)
  );

  demux64x1_8_buf #(.WIDTH(64), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4), .out_ack(out_ack),
    .accept_cnt(accept_cnt4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  s;
    logic [63:0] d;
    logic [7:0]  ack;
    logic        rdy;
    logic [7:0]  vld;
    logic [15:0] cnt;
    logic [2:0]  ch;
    logic [63:0] dat;
  } vec_t;

  vec_t vecs [17];

  logic [7:0]  mv;
  logic [15:0] mcnt;
  logic [63:0] q [8][$];
  logic [63:0] w;
  logic        exp_rdy, acc, hold;

  initial begin
    // routing
    vecs[0]  = '{1'b1, 3'd0, 64'h0000, 8'h00, 1'b1, 8'h01, 16'd1, 3'd0, 64'h0000};
    vecs[1]  = '{1'b1, 3'd1, 64'h1111, 8'h00, 1'b1, 8'h03, 16'd2, 3'd1, 64'h1111};
    vecs[2]  = '{1'b1, 3'd2, 64'h2222, 8'h00, 1'b1, 8'h07, 16'd3, 3'd2, 64'h2222};
    vecs[3]  = '{1'b1, 3'd3, 64'h3333, 8'h00, 1'b1, 8'h0F, 16'd4, 3'd3, 64'h3333};
    vecs[4]  = '{1'b1, 3'd4, 64'h4444, 8'h00, 1'b1, 8'h1F, 16'd5, 3'd4, 64'h4444};
    vecs[5]  = '{1'b1, 3'd5, 64'h5555, 8'h00, 1'b1, 8'h3F, 16'd6, 3'd5, 64'h5555};
    vecs[6]  = '{1'b1, 3'd6, 64'h6666, 8'h00, 1'b1, 8'h7F, 16'd7, 3'd6, 64'h6666};
    vecs[7]  = '{1'b1, 3'd7, 64'h7777, 8'h00, 1'b1, 8'hFF, 16'd8, 3'd7, 64'h7777};
    // backpressure, then refill with ack
    vecs[8]  = '{1'b1, 3'd3, 64'hDEAD, 8'h00, 1'b0, 8'hFF, 16'd8, 3'd3, 64'h3333};
    vecs[9]  = '{1'b1, 3'd3, 64'hDEAD, 8'h08, 1'b1, 8'hFF, 16'd9, 3'd3, 64'hDEAD};
    // ack-only, then acks on empty channels
    vecs[10] = '{1'b0, 3'd0, 64'h0,    8'h05, 1'b1, 8'hFA, 16'd9, 3'd2, 64'h2222};
    vecs[11] = '{1'b0, 3'd0, 64'h0,    8'h05, 1'b1, 8'hFA, 16'd9, 3'd0, 64'h0000};
    vecs[12] = '{1'b0, 3'd1, 64'h0,    8'h02, 1'b1, 8'hF8, 16'd9, 3'd1, 64'h1111};
    vecs[13] = '{1'b0, 3'd1, 64'h0,    8'h02, 1'b1, 8'hF8, 16'd9, 3'd1, 64'h1111};
    // accept into one channel while another is acked
    vecs[14] = '{1'b1, 3'd0, 64'hAAAA, 8'h10, 1'b1, 8'hE9, 16'd10, 3'd0, 64'hAAAA};
    vecs[15] = '{1'b1, 3'd5, 64'hBBBB, 8'h40, 1'b0, 8'hA9, 16'd10, 3'd5, 64'h5555};
    vecs[16] = '{1'b1, 3'd7, 64'hCCCC, 8'h80, 1'b1, 8'hA9, 16'd11, 3'd7, 64'hCCCC};

    reset = 1'b1; in_valid = 1'b0; sel = 3'd0; in_data = '0; out_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 8'h00);
    chk("rst_cnt", accept_cnt, 16'h0);
    for (int i = 0; i < 8; i++) chk("rst_data", out_data[i], 64'h0);
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #1 chk("rst_ready", in_ready, 1'b1);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 17; k++) begin
      in_valid = vecs[k].v; sel = vecs[k].s; in_data = vecs[k].d; out_ack = vecs[k].ack;
      #1 chk($sformatf("vec%0d_ready", k), in_ready, vecs[k].rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", k), out_valid, vecs[k].vld);
      chk($sformatf("vec%0d_cnt", k), accept_cnt, vecs[k].cnt);
      chk($sformatf("vec%0d_data", k), out_data[vecs[k].ch], vecs[k].dat);
    end

    // counter wrap on the 4-bit instance, pass-through on channel 0
    reset = 1'b1; in_valid = 1'b0; out_ack = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      in_valid = 1'b1; sel = 3'd0; in_data = 64'(k); out_ack = 8'h01;
      @(posedge clk); #1;
    end
    chk("wrap_cnt4_pre", accept_cnt4, 4'd15);
    chk("wrap_cnt16_pre", accept_cnt, 16'd15);
    chk("wrap_data_pre", out_data[0], 64'd15);
    in_data = 64'd16;
    @(posedge clk); #1;
    chk("wrap_cnt4", accept_cnt4, 4'd0);
    chk("wrap_cnt16", accept_cnt, 16'd16);
    chk("wrap_valid", out_valid, 8'h01);

    // reset wins over a same-cycle accept
    reset = 1'b1; in_valid = 1'b1; sel = 3'd2; in_data = 64'hBEEF; out_ack = '0;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    chk("rstacc_valid", out_valid, 8'h00);
    chk("rstacc_cnt", accept_cnt, 16'h0);
    chk("rstacc_data2", out_data[2], 64'h0);
    chk("rstacc_data0", out_data[0], 64'h0);

    // random traffic against a scoreboard
    mv = '0; mcnt = '0; hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        sel      = 3'($urandom_range(0, 7));
        in_data  = {$urandom, $urandom};
      end
      out_ack = 8'($urandom & $urandom);
      #1;
      exp_rdy = ~mv[sel] | out_ack[sel];
      chk("rnd_ready", in_ready, exp_rdy);
      acc = in_valid & exp_rdy;
      for (int i = 0; i < 8; i++) begin
        if (out_ack[i] && mv[i]) begin
          if (q[i].size() == 0) begin
            chk("rnd_underflow", 64'(q[i].size()), 64'd1);
          end else begin
            w = q[i].pop_front();
            chk("rnd_data", out_data[i], w);
          end
          mv[i] = 1'b0;
        end
      end
      if (acc) begin
        q[sel].push_back(in_data);
        mv[sel] = 1'b1;
        mcnt++;
      end
      @(posedge clk); #1;
      chk("rnd_valid", out_valid, mv);
      chk("rnd_cnt", accept_cnt, mcnt);
      hold = in_valid & ~acc;
    end
    in_valid = 1'b0; out_ack = '0;
    for (int i = 0; i < 8; i++) begin
      chk("drain_depth", 64'(q[i].size()), 64'(mv[i]));
      if (mv[i] && q[i].size() > 0) chk("drain_data", out_data[i], q[i][0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
